// File: rtl/passwd_pkg.sv
// Shared types and constants for the six-digit password controller.
package passwd_pkg;

  localparam int unsigned DIGITS  = 6;
  localparam int unsigned PAIRS   = 3;
  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ERR_W   = 3;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [DIGITS-1:0][DIGIT_W-1:0] code_t;

  // One register load: the two digits written together by a single yk pulse
  typedef struct packed {
    digit_t d1;
    digit_t d2;
  } pair_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY     = 3'd1,
    S_CHECK     = 3'd2,
    S_OPEN      = 3'd3,
    S_SET_ENTRY = 3'd4,
    S_SET_WRITE = 3'd5,
    S_LOCKOUT   = 3'd6
  } state_t;

  function automatic logic is_bcd(input digit_t d);
    return d <= DIGIT_W'(BCD_MAX);
  endfunction

  function automatic pair_t code_pair(input code_t c, input logic [1:0] k);
    pair_t p;
    p = '0;
    case (k)
      2'd0: begin p.d1 = c[0]; p.d2 = c[1]; end
      2'd1: begin p.d1 = c[2]; p.d2 = c[3]; end
      2'd2: begin p.d1 = c[4]; p.d2 = c[5]; end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/passwd_controller_if.sv
// Keypad, password-register and status signals of the password controller.
interface passwd_controller_if;
  import passwd_pkg::*;

  logic                 key_valid;
  digit_t               key_digit;
  logic                 key_enter;
  logic                 key_set;
  logic                 key_cancel;

  digit_t               q1, q2, q3, q4, q5, q6;

  digit_t               d1, d2;
  logic                 y0, y1, y2;
  logic                 unlocked;
  logic                 alarm;
  logic [ERR_W-1:0]     err_cnt;
  logic [CNT_W-1:0]     digit_cnt;

  modport master (
    output key_valid, key_digit, key_enter, key_set, key_cancel,
    output q1, q2, q3, q4, q5, q6,
    input  d1, d2, y0, y1, y2, unlocked, alarm, err_cnt, digit_cnt
  );

  modport slave (
    input  key_valid, key_digit, key_enter, key_set, key_cancel,
    input  q1, q2, q3, q4, q5, q6,
    output d1, d2, y0, y1, y2, unlocked, alarm, err_cnt, digit_cnt
  );

endinterface

// File: rtl/passwd_lock_timer.sv
// Lockout down-counter: loads LOCK_CYCLES-1, counts down while enabled, done at zero.
module passwd_lock_timer #(
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned LOCK_W      = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_done_c
);

  localparam logic [LOCK_W-1:0] LOAD_VAL = LOCK_W'(LOCK_CYCLES - 1);

  logic [LOCK_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - LOCK_W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/passwd_controller.sv
// Password entry/check/lockout FSM; writes a new code to the register as three pair loads.
module passwd_controller
  import passwd_pkg::*;
#(
  parameter int unsigned MAX_ERR     = 3,
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned LOCK_W      = 16
) (
  input  logic                clk,
  input  logic                clr,
  passwd_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * PAIRS - 1);

  state_t             r_state, w_state_next;
  code_t              r_buf, w_buf_next, w_buf_app;
  logic [CNT_W-1:0]   r_digit_cnt, w_digit_cnt_next, w_cnt_app;
  logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_next, w_err_inc;
  logic [CNT_W-1:0]   r_wr_step, w_wr_step_next;
  digit_t             r_d1, r_d2, w_d1_next, w_d2_next;
  logic               r_unlocked, r_alarm;
  logic [PAIRS-1:0]   r_y;
  pair_t              w_pair;
  code_t              w_stored;
  logic               w_match;
  logic               w_cancel, w_enter, w_set, w_digit;
  logic               w_timer_load, w_timer_en, w_timer_done;

  // Strobe priority: cancel > enter > set > digit
  assign w_cancel = bus.key_cancel;
  assign w_enter  = bus.key_enter && !w_cancel;
  assign w_set    = bus.key_set && !w_cancel && !bus.key_enter;
  assign w_digit  = bus.key_valid && is_bcd(bus.key_digit) &&
                    !w_cancel && !bus.key_enter && !bus.key_set;

  assign w_stored = {bus.q6, bus.q5, bus.q4, bus.q3, bus.q2, bus.q1};
  assign w_match  = (r_digit_cnt == FULL_CNT) && (r_buf == w_stored);
  assign w_err_inc = r_err_cnt + ERR_W'(1);

  // Buffer contents and count after accepting the current digit; a 7th digit is dropped
  always_comb begin
    w_buf_app = r_buf;
    w_cnt_app = r_digit_cnt;
    if (r_digit_cnt < FULL_CNT) begin
      w_buf_app[r_digit_cnt] = bus.key_digit;
      w_cnt_app              = r_digit_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_buf_next       = r_buf;
    w_digit_cnt_next = r_digit_cnt;
    w_err_cnt_next   = r_err_cnt;
    w_wr_step_next   = r_wr_step;
    w_d1_next        = r_d1;
    w_d2_next        = r_d2;
    w_pair           = '0;
    w_timer_load     = 1'b0;
    w_timer_en       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_digit) begin
          w_buf_next       = w_buf_app;
          w_digit_cnt_next = w_cnt_app;
          w_state_next     = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (w_cancel) begin
          w_buf_next       = '0;
          w_digit_cnt_next = '0;
          w_state_next     = S_IDLE;
        end else if (w_enter) begin
          w_state_next = S_CHECK;
        end else if (w_digit) begin
          w_buf_next       = w_buf_app;
          w_digit_cnt_next = w_cnt_app;
        end
      end

      S_CHECK: begin
        w_buf_next       = '0;
        w_digit_cnt_next = '0;
        if (w_match) begin
          w_err_cnt_next = '0;
          w_state_next   = S_OPEN;
        end else begin
          w_err_cnt_next = w_err_inc;
          if (w_err_inc >= ERR_W'(MAX_ERR)) begin
            w_timer_load = 1'b1;
            w_state_next = S_LOCKOUT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end

      S_OPEN: begin
        if (w_cancel) begin
          w_state_next = S_IDLE;
        end else if (w_set) begin
          w_state_next = S_SET_ENTRY;
        end
      end

      S_SET_ENTRY: begin
        if (w_cancel) begin
          w_buf_next       = '0;
          w_digit_cnt_next = '0;
          w_state_next     = S_OPEN;
        end else if (w_enter) begin
          if (r_digit_cnt == FULL_CNT) begin
            w_pair         = code_pair(r_buf, 2'd0);
            w_d1_next      = w_pair.d1;
            w_d2_next      = w_pair.d2;
            w_wr_step_next = '0;
            w_state_next   = S_SET_WRITE;
          end
        end else if (w_digit) begin
          w_buf_next       = w_buf_app;
          w_digit_cnt_next = w_cnt_app;
        end
      end

      // Even steps present a new pair on d1/d2; odd steps carry the falling-edge load pulse
      S_SET_WRITE: begin
        if (r_wr_step == LAST_STEP) begin
          w_buf_next       = '0;
          w_digit_cnt_next = '0;
          w_wr_step_next   = '0;
          w_state_next     = S_OPEN;
        end else begin
          w_wr_step_next = r_wr_step + CNT_W'(1);
          if (!w_wr_step_next[0]) begin
            w_pair    = code_pair(r_buf, w_wr_step_next[2:1]);
            w_d1_next = w_pair.d1;
            w_d2_next = w_pair.d2;
          end
        end
      end

      S_LOCKOUT: begin
        w_timer_en = 1'b1;
        if (w_timer_done) begin
          w_err_cnt_next = '0;
          w_state_next   = S_IDLE;
        end
      end

      default: begin
        w_buf_next       = '0;
        w_digit_cnt_next = '0;
        w_state_next     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_digit_cnt <= '0;
      r_err_cnt   <= '0;
      r_wr_step   <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_unlocked  <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_buf       <= w_buf_next;
      r_digit_cnt <= w_digit_cnt_next;
      r_err_cnt   <= w_err_cnt_next;
      r_wr_step   <= w_wr_step_next;
      r_d1        <= w_d1_next;
      r_d2        <= w_d2_next;
      r_unlocked  <= (w_state_next inside {S_OPEN, S_SET_ENTRY, S_SET_WRITE});
      r_alarm     <= (w_state_next == S_LOCKOUT);
    end
  end

  // Load enables change only while clk is low, so clk & yk yields one clean edge per slot
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      r_y <= '0;
    end else begin
      for (int k = 0; k < int'(PAIRS); k++) begin
        r_y[k] <= (r_state == S_SET_WRITE) && (r_wr_step == CNT_W'(2 * k));
      end
    end
  end

  passwd_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES),
    .LOCK_W      (LOCK_W)
  ) u_lock_timer (
    .clk      (clk),
    .clr      (clr),
    .i_load   (w_timer_load),
    .i_en     (w_timer_en),
    .o_done_c (w_timer_done)
  );

  assign bus.d1        = r_d1;
  assign bus.d2        = r_d2;
  assign bus.y0        = r_y[0];
  assign bus.y1        = r_y[1];
  assign bus.y2        = r_y[2];
  assign bus.unlocked  = r_unlocked;
  assign bus.alarm     = r_alarm;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_passwd_controller.sv
// Bench for passwd_controller with a gated-clock model of the password register.
module tb_passwd_controller;
  import passwd_pkg::*;

  localparam int unsigned MAX_ERR     = 3;
  localparam int unsigned LOCK_CYCLES = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  passwd_controller_if bus();

  passwd_controller #(
    .MAX_ERR     (MAX_ERR),
    .LOCK_CYCLES (LOCK_CYCLES),
    .LOCK_W      (16)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Password register: each pair captures on clk gated by its load enable
  logic [7:0] rq_p0 = 8'h12;
  logic [7:0] rq_p1 = 8'h34;
  logic [7:0] rq_p2 = 8'h56;
  int cap0 = 0, cap1 = 0, cap2 = 0;
  wire g0 = clk & bus.y0;
  wire g1 = clk & bus.y1;
  wire g2 = clk & bus.y2;
  always @(posedge g0) begin rq_p0 <= {bus.d1, bus.d2}; cap0 <= cap0 + 1; end
  always @(posedge g1) begin rq_p1 <= {bus.d1, bus.d2}; cap1 <= cap1 + 1; end
  always @(posedge g2) begin rq_p2 <= {bus.d1, bus.d2}; cap2 <= cap2 + 1; end
  assign bus.q1 = rq_p0[7:4];
  assign bus.q2 = rq_p0[3:0];
  assign bus.q3 = rq_p1[7:4];
  assign bus.q4 = rq_p1[3:0];
  assign bus.q5 = rq_p2[7:4];
  assign bus.q6 = rq_p2[3:0];
  wire [23:0] reg_word = {rq_p0, rq_p1, rq_p2};

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [23:0] ref_code = 24'h123456;
  int          m_err    = 0;
  bit          m_open   = 1'b0;

  typedef struct {
    int          n;
    logic [31:0] code;
    int          exp_dcnt;
    int          exp_unl;
    int          exp_err;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_seq(input int n, input logic [31:0] code);
    for (int i = 0; i < n; i++) begin
      bus.key_valid = 1'b1;
      bus.key_digit = 4'(code >> (4 * (n - 1 - i)));
      step();
      bus.key_valid = 1'b0;
    end
  endtask

  task automatic do_enter();  bus.key_enter  = 1'b1; step(); bus.key_enter  = 1'b0; endtask
  task automatic do_set();    bus.key_set    = 1'b1; step(); bus.key_set    = 1'b0; endtask
  task automatic do_cancel(); bus.key_cancel = 1'b1; step(); bus.key_cancel = 1'b0; endtask

  task automatic relock();
    do_cancel();
    check("relock unlocked", int'(bus.unlocked), 0);
    m_open = 1'b0;
  endtask

  // Attempt a code; expectations come from the buffering/match rules, not from the DUT
  task automatic model_attempt(input int n, input logic [31:0] code);
    logic [23:0] ent;
    logic [3:0]  dg;
    int          cnt;
    ent = '0;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      dg = 4'(code >> (4 * (n - 1 - i)));
      if (dg <= 4'd9 && cnt < 6) begin
        ent = {ent[19:0], dg};
        cnt++;
      end
    end
    press_seq(n, code);
    check("attempt digit_cnt", int'(bus.digit_cnt), cnt);
    do_enter();
    step();
    if (cnt != 0) begin
      if (cnt == 6 && ent == ref_code) begin
        m_err  = 0;
        m_open = 1'b1;
      end else begin
        m_err++;
      end
    end
    check("attempt unlocked", int'(bus.unlocked), int'(m_open));
    check("attempt err_cnt", int'(bus.err_cnt), m_err);
    check("attempt alarm", int'(bus.alarm), int'(m_err >= int'(MAX_ERR)));
  endtask

  // Change the password from OPEN and check every write cycle plus the register afterwards
  task automatic do_write(input logic [23:0] code);
    int c0, c1, c2, ey;
    logic [3:0] ed1, ed2;
    c0 = cap0; c1 = cap1; c2 = cap2;
    do_set();
    press_seq(6, {8'h00, code});
    do_enter();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      ed1 = 4'(code >> (4 * (5 - 2 * (k / 2))));
      ed2 = 4'(code >> (4 * (4 - 2 * (k / 2))));
      ey  = (k % 2 == 1) ? (1 << (k / 2)) : 0;
      check("write y2y1y0", int'({bus.y2, bus.y1, bus.y0}), ey);
      check("write d1", int'(bus.d1), int'(ed1));
      check("write d2", int'(bus.d2), int'(ed2));
    end
    step();
    check("post-write y", int'({bus.y2, bus.y1, bus.y0}), 0);
    check("post-write digit_cnt", int'(bus.digit_cnt), 0);
    check("post-write unlocked", int'(bus.unlocked), 1);
    check("captures slot0", cap0 - c0, 1);
    check("captures slot1", cap1 - c1, 1);
    check("captures slot2", cap2 - c2, 1);
    check("register contents", int'(reg_word), int'(code));
    ref_code = code;
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_digit  = '0;
    bus.key_enter  = 1'b0;
    bus.key_set    = 1'b0;
    bus.key_cancel = 1'b0;

    tbl[0] = '{6, 32'h123456,  6, 1, 0};
    tbl[1] = '{5, 32'h12345,   5, 0, 1};
    tbl[2] = '{7, 32'h1234567, 6, 1, 0};
    tbl[3] = '{7, 32'h12345A6, 6, 1, 0};
    tbl[4] = '{6, 32'h654321,  6, 0, 1};
    tbl[5] = '{6, 32'h000000,  6, 0, 2};
    tbl[6] = '{6, 32'h123456,  6, 1, 0};

    #2 clr = 1'b0;
    #1;
    check("reset d1", int'(bus.d1), 0);
    check("reset d2", int'(bus.d2), 0);
    check("reset y", int'({bus.y2, bus.y1, bus.y0}), 0);
    check("reset unlocked", int'(bus.unlocked), 0);
    check("reset alarm", int'(bus.alarm), 0);
    check("reset err_cnt", int'(bus.err_cnt), 0);
    check("reset digit_cnt", int'(bus.digit_cnt), 0);
    step();
    step();
    clr = 1'b1;
    step();

    foreach (tbl[i]) begin
      press_seq(tbl[i].n, tbl[i].code);
      check("vec digit_cnt", int'(bus.digit_cnt), tbl[i].exp_dcnt);
      do_enter();
      check("vec unlocked in CHECK", int'(bus.unlocked), 0);
      step();
      check("vec unlocked", int'(bus.unlocked), tbl[i].exp_unl);
      check("vec err_cnt", int'(bus.err_cnt), tbl[i].exp_err);
      check("vec alarm", int'(bus.alarm), 0);
      m_err = tbl[i].exp_err;
      if (tbl[i].exp_unl != 0) relock();
    end

    // Cancel together with a digit clears the buffer
    press_seq(3, 32'h123);
    bus.key_cancel = 1'b1;
    bus.key_valid  = 1'b1;
    bus.key_digit  = 4'd4;
    step();
    bus.key_cancel = 1'b0;
    bus.key_valid  = 1'b0;
    check("cancel+digit digit_cnt", int'(bus.digit_cnt), 0);
    model_attempt(6, 32'h123456);

    // Short enter in SET_ENTRY is ignored; cancel returns to OPEN
    do_set();
    press_seq(3, 32'h987);
    do_enter();
    check("short set enter digit_cnt", int'(bus.digit_cnt), 3);
    check("short set enter y", int'({bus.y2, bus.y1, bus.y0}), 0);
    step();
    check("short set enter no write", int'({bus.y2, bus.y1, bus.y0}), 0);
    do_cancel();
    check("set cancel digit_cnt", int'(bus.digit_cnt), 0);
    check("set cancel unlocked", int'(bus.unlocked), 1);

    do_write(24'h987654);
    relock();
    model_attempt(6, 32'h987654);
    relock();

    // Three failures lock out for exactly LOCK_CYCLES cycles; digits meanwhile are dropped
    for (int a = 0; a < 3; a++) model_attempt(6, 32'h111111);
    for (int c = 1; c < int'(LOCK_CYCLES); c++) begin
      bus.key_valid = 1'b1;
      bus.key_digit = 4'(c);
      step();
      check("lockout alarm held", int'(bus.alarm), 1);
      check("lockout digit_cnt", int'(bus.digit_cnt), 0);
    end
    bus.key_valid = 1'b0;
    step();
    m_err = 0;
    check("lockout end alarm", int'(bus.alarm), 0);
    check("lockout end err_cnt", int'(bus.err_cnt), 0);
    check("lockout end digit_cnt", int'(bus.digit_cnt), 0);
    model_attempt(6, 32'h987654);

    // Random password changes, each followed by an optional bad attempt and a good one
    for (int it = 0; it < 100; it++) begin
      logic [23:0] nc;
      logic [31:0] wc;
      int          wn;
      nc = '0;
      for (int j = 0; j < 6; j++) nc = {nc[19:0], 4'($urandom_range(0, 9))};
      do_write(nc);
      relock();
      if ($urandom_range(0, 1) == 1) begin
        wn = int'($urandom_range(1, 7));
        wc = '0;
        for (int j = 0; j < wn; j++) wc = {wc[27:0], 4'($urandom_range(0, 11))};
        model_attempt(wn, wc);
        if (m_open) relock();
      end
      model_attempt(6, {8'h00, nc});
    end

    // Reset while slot 1 is loading: y1 drops at once, pairs 0-1 new and pair 2 old remain
    begin
      logic [23:0] nc;
      nc = 24'h246802;
      do_set();
      press_seq(6, {8'h00, nc});
      do_enter();
      step();
      step();
      step();
      check("slot1 y1 before reset", int'(bus.y1), 1);
      clr = 1'b0;
      #1;
      check("async reset y", int'({bus.y2, bus.y1, bus.y0}), 0);
      check("async reset d1", int'(bus.d1), 0);
      check("async reset d2", int'(bus.d2), 0);
      check("async reset unlocked", int'(bus.unlocked), 0);
      check("async reset alarm", int'(bus.alarm), 0);
      check("async reset err_cnt", int'(bus.err_cnt), 0);
      check("async reset digit_cnt", int'(bus.digit_cnt), 0);
      check("partial register", int'(reg_word), int'({nc[23:8], ref_code[7:0]}));
      ref_code = {nc[23:8], ref_code[7:0]};
      m_err    = 0;
      m_open   = 1'b0;
      step();
      clr = 1'b1;
      step();
      model_attempt(6, {8'h00, ref_code});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
